// File: rtl/strm_pkg.sv
// Shared definitions for the AXI-Stream traffic generator/checker:
// register map, MODE/STATUS bit positions, FSM states and the pattern LFSR.
package strm_pkg;

    localparam logic [31:0] ADDR_TX_COUNT  = 32'h0000_0000;
    localparam logic [31:0] ADDR_RX_COUNT  = 32'h0000_0008;
    localparam logic [31:0] ADDR_TX_DEST   = 32'h0000_0010;
    localparam logic [31:0] ADDR_PKT_LEN   = 32'h0000_0018;
    localparam logic [31:0] ADDR_MODE      = 32'h0000_0020;
    localparam logic [31:0] ADDR_SEED      = 32'h0000_0028;
    localparam logic [31:0] ADDR_TX_CYC    = 32'h0000_0030;
    localparam logic [31:0] ADDR_RX_CYC    = 32'h0000_0038;
    localparam logic [31:0] ADDR_ERR_COUNT = 32'h0000_0040;
    localparam logic [31:0] ADDR_LAST_CNT  = 32'h0000_0048;
    localparam logic [31:0] ADDR_FIRST_ERR = 32'h0000_0050;
    localparam logic [31:0] ADDR_LAST_TID  = 32'h0000_0058;
    localparam logic [31:0] ADDR_STATUS    = 32'h0000_0060;

    localparam int MODE_LFSR    = 0;
    localparam int MODE_CHECK   = 1;
    localparam int MODE_ROTATE  = 2;

    localparam int STAT_TX_IGN  = 0;
    localparam int STAT_TX_BUSY = 1;
    localparam int STAT_RX_BUSY = 2;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RECV = 2'd2
    } strm_state_e;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [63:0] data;
    } softreg_req_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } softreg_resp_t;

    // Right-shifting Galois step; the mask holds taps 32,22,2,1.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] shifted;
        shifted = {1'b0, s[31:1]};
        if (s[0]) begin
            lfsr_next = shifted ^ LFSR_POLY;
        end else begin
            lfsr_next = shifted;
        end
    endfunction

endpackage

// File: rtl/strm_pattern.sv
// Beat pattern source: a 32-bit counter or LFSR word replicated across all lanes.
// TX and RX each own one instance so both sides walk the same sequence.
module strm_pattern
    import strm_pkg::*;
#(
    parameter int DATA_W = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       seed,
    input  logic              lfsr_mode,
    input  logic              load,
    input  logic              advance,
    output logic [DATA_W-1:0] data
);

    localparam int LANES = DATA_W / 32;

    logic [31:0] state_r;
    logic        lfsr_r;

    // Pattern state: load reseeds and latches the mode, advance steps one beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= 32'd0;
            lfsr_r  <= 1'b0;
        end else if (load) begin
            lfsr_r <= lfsr_mode;
            if (!lfsr_mode) begin
                state_r <= 32'd0;
            end else if (seed == 32'd0) begin
                state_r <= 32'd1;
            end else begin
                state_r <= seed;
            end
        end else if (advance) begin
            if (lfsr_r) begin
                state_r <= lfsr_next(state_r);
            end else begin
                state_r <= state_r + 32'd1;
            end
        end
    end

    assign data = {LANES{state_r}};

endmodule

// File: rtl/axis_strm_gen.sv
// AXI-Stream traffic generator and matching receive-side checker,
// programmed and observed through a 64-bit soft register port.
module axis_strm_gen
    import strm_pkg::*;
#(
    parameter int  DATA_W = 512,
    parameter int  N_DEST = 32,
    parameter int  CNT_W  = 35,
    parameter int  CYC_W  = 48,
    localparam int DEST_W = $clog2(N_DEST)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  softreg_req_t      softreg_req,
    output softreg_resp_t     softreg_resp,
    output logic              axis_tx_tvalid,
    input  logic              axis_tx_tready,
    output logic [DATA_W-1:0] axis_tx_tdata,
    output logic [DEST_W-1:0] axis_tx_tdest,
    output logic              axis_tx_tlast,
    input  logic              axis_rx_tvalid,
    output logic              axis_rx_tready,
    input  logic [DATA_W-1:0] axis_rx_tdata,
    input  logic [DEST_W-1:0] axis_rx_tid,
    input  logic              axis_rx_tlast
);

    logic              wr_s, rd_s;
    logic [CNT_W-1:0]  wr_cnt_s;
    logic              wr_tx_count_s, wr_rx_count_s;
    logic              unused_req_s;

    logic [DEST_W-1:0] tx_dest_cfg_r;
    logic [CNT_W-1:0]  pkt_len_r;
    logic [2:0]        mode_r;
    logic [31:0]       seed_r;

    strm_state_e       tx_state_r, tx_state_nxt_s;
    logic [CNT_W-1:0]  tx_count_r, tx_pkt_idx_r;
    logic [CYC_W-1:0]  tx_cyc_r;
    logic [DEST_W-1:0] tx_dest_r;
    logic              tx_ign_r;
    logic              tx_load_s, tx_fire_s, tx_last_s;
    logic [DATA_W-1:0] tx_pat_s;

    strm_state_e       rx_state_r, rx_state_nxt_s;
    logic [CNT_W-1:0]  rx_count_r, rx_pkt_idx_r, rx_beat_r;
    logic [CNT_W-1:0]  err_count_r, last_count_r, first_err_r;
    logic [CYC_W-1:0]  rx_cyc_r;
    logic [DEST_W-1:0] last_tid_r;
    logic              rx_fire_s, rx_exp_last_s, rx_err_s;
    logic [DATA_W-1:0] rx_pat_s;

    logic [63:0]       rd_data_s;
    softreg_resp_t     resp_r;

    assign wr_s          = softreg_req.valid && softreg_req.is_write;
    assign rd_s          = softreg_req.valid && !softreg_req.is_write;
    assign wr_cnt_s      = softreg_req.data[CNT_W-1:0];
    assign wr_tx_count_s = wr_s && (softreg_req.addr == ADDR_TX_COUNT);
    assign wr_rx_count_s = wr_s && (softreg_req.addr == ADDR_RX_COUNT);
    assign unused_req_s  = ^softreg_req.data[63:CNT_W];

    // Configuration registers written directly from the soft register port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_dest_cfg_r <= '0;
            pkt_len_r     <= '0;
            mode_r        <= 3'd0;
            seed_r        <= 32'd1;
        end else if (wr_s) begin
            case (softreg_req.addr)
                ADDR_TX_DEST: tx_dest_cfg_r <= softreg_req.data[DEST_W-1:0];
                ADDR_PKT_LEN: pkt_len_r     <= softreg_req.data[CNT_W-1:0];
                ADDR_MODE:    mode_r        <= softreg_req.data[2:0];
                ADDR_SEED:    seed_r        <= softreg_req.data[31:0];
                default:      mode_r        <= mode_r;
            endcase
        end
    end

    // ---------------------------------------------------------------- TX side
    assign tx_load_s = wr_tx_count_s && (tx_state_r == ST_IDLE);
    assign tx_fire_s = (tx_state_r == ST_SEND) && axis_tx_tready;
    assign tx_last_s = (tx_state_r == ST_SEND) && (tx_pkt_idx_r == pkt_len_r);

    // TX state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_r <= ST_IDLE;
        end else begin
            tx_state_r <= tx_state_nxt_s;
        end
    end

    // TX next state: a count load starts sending, the last handshake stops it.
    always_comb begin
        tx_state_nxt_s = tx_state_r;
        case (tx_state_r)
            ST_IDLE: begin
                if (wr_tx_count_s && (wr_cnt_s != '0)) begin
                    tx_state_nxt_s = ST_SEND;
                end else begin
                    tx_state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (tx_fire_s && (tx_count_r == CNT_W'(1'b1))) begin
                    tx_state_nxt_s = ST_IDLE;
                end else begin
                    tx_state_nxt_s = ST_SEND;
                end
            end
            default: tx_state_nxt_s = ST_IDLE;
        endcase
    end

    // TX counters, packet framing and destination rotation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_count_r   <= '0;
            tx_cyc_r     <= '0;
            tx_pkt_idx_r <= '0;
            tx_dest_r    <= '0;
            tx_ign_r     <= 1'b0;
        end else begin
            if (wr_tx_count_s && (tx_state_r == ST_SEND)) begin
                tx_ign_r <= 1'b1;
            end
            if (tx_load_s) begin
                tx_count_r   <= wr_cnt_s;
                tx_cyc_r     <= '0;
                tx_pkt_idx_r <= '0;
                tx_dest_r    <= tx_dest_cfg_r;
            end else begin
                if ((tx_state_r == ST_SEND) && (tx_cyc_r != '1)) begin
                    tx_cyc_r <= tx_cyc_r + CYC_W'(1'b1);
                end
                if (tx_fire_s) begin
                    tx_count_r <= tx_count_r - CNT_W'(1'b1);
                    if (tx_last_s) begin
                        tx_pkt_idx_r <= '0;
                        if (mode_r[MODE_ROTATE]) begin
                            tx_dest_r <= tx_dest_r + DEST_W'(1'b1);
                        end
                    end else begin
                        tx_pkt_idx_r <= tx_pkt_idx_r + CNT_W'(1'b1);
                    end
                end
            end
        end
    end

    strm_pattern #(.DATA_W(DATA_W)) u_tx_pattern (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed      (seed_r),
        .lfsr_mode (mode_r[MODE_LFSR]),
        .load      (tx_load_s),
        .advance   (tx_fire_s),
        .data      (tx_pat_s)
    );

    // ---------------------------------------------------------------- RX side
    assign rx_fire_s     = (rx_state_r == ST_RECV) && axis_rx_tvalid;
    assign rx_exp_last_s = (rx_pkt_idx_r == pkt_len_r);
    assign rx_err_s      = (axis_rx_tdata != rx_pat_s) || (axis_rx_tlast != rx_exp_last_s);

    // RX state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_r <= ST_IDLE;
        end else begin
            rx_state_r <= rx_state_nxt_s;
        end
    end

    // RX next state: a count write always wins over a same-cycle handshake.
    always_comb begin
        rx_state_nxt_s = rx_state_r;
        case (rx_state_r)
            ST_IDLE: begin
                if (wr_rx_count_s && (wr_cnt_s != '0)) begin
                    rx_state_nxt_s = ST_RECV;
                end else begin
                    rx_state_nxt_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (wr_rx_count_s) begin
                    rx_state_nxt_s = (wr_cnt_s != '0) ? ST_RECV : ST_IDLE;
                end else if (rx_fire_s && (rx_count_r == CNT_W'(1'b1))) begin
                    rx_state_nxt_s = ST_IDLE;
                end else begin
                    rx_state_nxt_s = ST_RECV;
                end
            end
            default: rx_state_nxt_s = ST_IDLE;
        endcase
    end

    // RX counters and checker; FIRST_ERR uses all-ones as its "no error" value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_count_r   <= '0;
            rx_cyc_r     <= '0;
            rx_pkt_idx_r <= '0;
            rx_beat_r    <= '0;
            err_count_r  <= '0;
            last_count_r <= '0;
            first_err_r  <= '1;
            last_tid_r   <= '0;
        end else if (wr_rx_count_s) begin
            rx_count_r   <= wr_cnt_s;
            rx_cyc_r     <= '0;
            rx_pkt_idx_r <= '0;
            rx_beat_r    <= '0;
            err_count_r  <= '0;
            last_count_r <= '0;
            first_err_r  <= '1;
        end else begin
            if ((rx_state_r == ST_RECV) && (rx_cyc_r != '1)) begin
                rx_cyc_r <= rx_cyc_r + CYC_W'(1'b1);
            end
            if (rx_fire_s) begin
                rx_count_r   <= rx_count_r - CNT_W'(1'b1);
                rx_beat_r    <= rx_beat_r + CNT_W'(1'b1);
                rx_pkt_idx_r <= rx_exp_last_s ? '0 : rx_pkt_idx_r + CNT_W'(1'b1);
                last_tid_r   <= axis_rx_tid;
                if (axis_rx_tlast && (last_count_r != '1)) begin
                    last_count_r <= last_count_r + CNT_W'(1'b1);
                end
                if (mode_r[MODE_CHECK] && rx_err_s) begin
                    if (err_count_r != '1) begin
                        err_count_r <= err_count_r + CNT_W'(1'b1);
                    end
                    if (first_err_r == '1) begin
                        first_err_r <= rx_beat_r;
                    end
                end
            end
        end
    end

    strm_pattern #(.DATA_W(DATA_W)) u_rx_pattern (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed      (seed_r),
        .lfsr_mode (mode_r[MODE_LFSR]),
        .load      (wr_rx_count_s),
        .advance   (rx_fire_s),
        .data      (rx_pat_s)
    );

    // ------------------------------------------------------- register readback
    // Read data mux; unmapped addresses read as zero.
    always_comb begin
        rd_data_s = 64'd0;
        case (softreg_req.addr)
            ADDR_TX_COUNT:  rd_data_s = 64'(tx_count_r);
            ADDR_RX_COUNT:  rd_data_s = 64'(rx_count_r);
            ADDR_TX_DEST:   rd_data_s = 64'(tx_dest_cfg_r);
            ADDR_PKT_LEN:   rd_data_s = 64'(pkt_len_r);
            ADDR_MODE:      rd_data_s = 64'(mode_r);
            ADDR_SEED:      rd_data_s = 64'(seed_r);
            ADDR_TX_CYC:    rd_data_s = 64'(tx_cyc_r);
            ADDR_RX_CYC:    rd_data_s = 64'(rx_cyc_r);
            ADDR_ERR_COUNT: rd_data_s = 64'(err_count_r);
            ADDR_LAST_CNT:  rd_data_s = 64'(last_count_r);
            ADDR_FIRST_ERR: rd_data_s = 64'(first_err_r);
            ADDR_LAST_TID:  rd_data_s = 64'(last_tid_r);
            ADDR_STATUS:    rd_data_s = 64'({rx_state_r == ST_RECV,
                                             tx_state_r == ST_SEND,
                                             tx_ign_r});
            default:        rd_data_s = 64'd0;
        endcase
    end

    // One-cycle registered read response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_r <= '0;
        end else begin
            resp_r.valid <= rd_s;
            resp_r.data  <= rd_s ? rd_data_s : 64'd0;
        end
    end

    assign softreg_resp   = resp_r;
    assign axis_tx_tvalid = (tx_state_r == ST_SEND);
    assign axis_tx_tdata  = tx_pat_s;
    assign axis_tx_tdest  = tx_dest_r;
    assign axis_tx_tlast  = tx_last_s;
    assign axis_rx_tready = (rx_state_r == ST_RECV);

endmodule

// File: tb/tb_axis_strm_gen.sv
// Directed loopback bench for axis_strm_gen: tx feeds rx through a path that
// can stall the handshake or corrupt selected beats.
module tb_axis_strm_gen;
    import strm_pkg::*;

    localparam int DATA_W = 512;
    localparam int N_DEST = 32;
    localparam int CNT_W  = 35;
    localparam int CYC_W  = 48;
    localparam int DEST_W = 5;
    localparam logic [DATA_W-1:0] LANE0_BIT = 1;

    logic clk = 1'b0;
    logic rst_n;
    softreg_req_t  req;
    softreg_resp_t resp;

    logic              tx_tvalid, tx_tready, tx_tlast;
    logic [DATA_W-1:0] tx_tdata;
    logic [DEST_W-1:0] tx_tdest;
    logic              rx_tvalid, rx_tready, rx_tlast;
    logic [DATA_W-1:0] rx_tdata;
    logic [DEST_W-1:0] rx_tid;

    logic stall, corrupt_en, hs_clr;
    int   hs_cnt, stall_cnt;
    logic unstable, prev_stall, prev_last;
    logic [DATA_W-1:0] prev_data;
    logic [DEST_W-1:0] prev_dest;
    logic [DATA_W-1:0] cap_data [0:15];
    logic [DEST_W-1:0] cap_dest [0:15];
    logic              cap_last [0:15];

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] d;

    axis_strm_gen #(.DATA_W(DATA_W), .N_DEST(N_DEST), .CNT_W(CNT_W), .CYC_W(CYC_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .softreg_req    (req),
        .softreg_resp   (resp),
        .axis_tx_tvalid (tx_tvalid),
        .axis_tx_tready (tx_tready),
        .axis_tx_tdata  (tx_tdata),
        .axis_tx_tdest  (tx_tdest),
        .axis_tx_tlast  (tx_tlast),
        .axis_rx_tvalid (rx_tvalid),
        .axis_rx_tready (rx_tready),
        .axis_rx_tdata  (rx_tdata),
        .axis_rx_tid    (rx_tid),
        .axis_rx_tlast  (rx_tlast)
    );

    always #5 clk = ~clk;

    assign tx_tready = rx_tready & ~stall;
    assign rx_tvalid = tx_tvalid & ~stall;
    assign rx_tdata  = tx_tdata ^ ((corrupt_en && hs_cnt == 4) ? LANE0_BIT : '0);
    assign rx_tlast  = tx_tlast ^ (corrupt_en && hs_cnt == 7);
    assign rx_tid    = tx_tdest;

    // Capture handshaken beats, count stall cycles, flag changes while stalled.
    always @(posedge clk) begin
        if (hs_clr) begin
            hs_cnt     <= 0;
            stall_cnt  <= 0;
            unstable   <= 1'b0;
            prev_stall <= 1'b0;
        end else begin
            if (tx_tvalid && tx_tready) begin
                cap_data[hs_cnt[3:0]] <= tx_tdata;
                cap_dest[hs_cnt[3:0]] <= tx_tdest;
                cap_last[hs_cnt[3:0]] <= tx_tlast;
                hs_cnt <= hs_cnt + 1;
            end
            if (tx_tvalid && !tx_tready) stall_cnt <= stall_cnt + 1;
            if (prev_stall && (!tx_tvalid || tx_tdata != prev_data ||
                               tx_tdest != prev_dest || tx_tlast != prev_last))
                unstable <= 1'b1;
            prev_stall <= tx_tvalid && !tx_tready;
            prev_data  <= tx_tdata;
            prev_dest  <= tx_tdest;
            prev_last  <= tx_tlast;
        end
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All register tasks start and finish on a falling edge.
    task automatic reg_wr(input logic [31:0] a, input logic [63:0] v);
        req.valid = 1'b1; req.is_write = 1'b1; req.addr = a; req.data = v;
        @(negedge clk);
        req.valid = 1'b0; req.is_write = 1'b0;
    endtask

    task automatic reg_rd(input logic [31:0] a, output logic [63:0] v);
        req.valid = 1'b1; req.is_write = 1'b0; req.addr = a; req.data = 64'd0;
        @(negedge clk);
        req.valid = 1'b0;
        v = resp.valid ? resp.data : 64'hBAD0_BAD0_BAD0_BAD0;
    endtask

    task automatic clr_mon();
        hs_clr = 1'b1;
        @(negedge clk);
        hs_clr = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!tx_tvalid && !rx_tready) begin
                idle = 1'b1;
                break;
            end
        end
        chk(tag, idle, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] stall_pat;
        logic        done;
        req = '0; stall = 1'b0; corrupt_en = 1'b0; hs_clr = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", tx_tvalid, 1'b0);
        chk("rst_tready", rx_tready, 1'b0);
        chk("rst_resp_valid", resp.valid, 1'b0);
        chk("rst_tlast", tx_tlast, 1'b0);
        chk("rst_tdata", tx_tdata, 512'd0);
        rst_n = 1'b1;
        hs_clr = 1'b0;
        @(negedge clk);
        reg_rd(ADDR_FIRST_ERR, d); chk("rst_first_err", d, 64'h7_FFFF_FFFF);
        reg_rd(ADDR_SEED, d);      chk("rst_seed", d, 64'd1);
        reg_rd(ADDR_STATUS, d);    chk("rst_status", d, 64'd0);

        // Counter loopback, 2 packets of 4.
        clr_mon();
        reg_wr(ADDR_MODE, 64'h2);
        reg_wr(ADDR_PKT_LEN, 64'd3);
        reg_wr(ADDR_RX_COUNT, 64'd8);
        reg_wr(ADDR_TX_COUNT, 64'd8);
        wait_idle("t1_idle");
        chk("t1_beat0", cap_data[0], 512'd0);
        chk("t1_beat5", cap_data[5], {16{32'h0000_0005}});
        chk("t1_last2", cap_last[2], 1'b0);
        chk("t1_last3", cap_last[3], 1'b1);
        reg_rd(ADDR_ERR_COUNT, d); chk("t1_err", d, 64'd0);
        reg_rd(ADDR_LAST_CNT, d);  chk("t1_lastcnt", d, 64'd2);
        reg_rd(ADDR_TX_CYC, d);    chk("t1_txcyc", d, 64'd8);
        reg_rd(ADDR_RX_CYC, d);    chk("t1_rxcyc", d, 64'd9);
        reg_rd(ADDR_TX_COUNT, d);  chk("t1_txcount", d, 64'd0);
        reg_rd(ADDR_FIRST_ERR, d); chk("t1_first_err", d, 64'h7_FFFF_FFFF);
        reg_rd(32'h68, d);         chk("t1_unmapped", d, 64'd0);

        // LFSR with seed 0 (treated as 1).
        clr_mon();
        reg_wr(ADDR_MODE, 64'h3);
        reg_wr(ADDR_SEED, 64'd0);
        reg_wr(ADDR_RX_COUNT, 64'd4);
        reg_wr(ADDR_TX_COUNT, 64'd4);
        wait_idle("t2_idle");
        chk("t2_beat0", cap_data[0], {16{32'h0000_0001}});
        chk("t2_beat1", cap_data[1], {16{32'h8020_0003}});
        chk("t2_beat2", cap_data[2], {16{32'hC030_0002}});
        chk("t2_beat3", cap_data[3], {16{32'h6018_0001}});
        reg_rd(ADDR_ERR_COUNT, d); chk("t2_err", d, 64'd0);

        // Destination rotation, one-beat packets starting at N_DEST-1.
        clr_mon();
        reg_wr(ADDR_MODE, 64'h6);
        reg_wr(ADDR_TX_DEST, 64'd31);
        reg_wr(ADDR_PKT_LEN, 64'd0);
        reg_wr(ADDR_RX_COUNT, 64'd3);
        reg_wr(ADDR_TX_COUNT, 64'd3);
        wait_idle("t3_idle");
        chk("t3_dest0", cap_dest[0], 5'd31);
        chk("t3_dest1", cap_dest[1], 5'd0);
        chk("t3_dest2", cap_dest[2], 5'd1);
        chk("t3_last1", cap_last[1], 1'b1);
        reg_rd(ADDR_LAST_CNT, d); chk("t3_lastcnt", d, 64'd3);
        reg_rd(ADDR_LAST_TID, d); chk("t3_last_tid", d, 64'd1);

        // Handshake stalls from a fixed pattern.
        clr_mon();
        stall_pat = 16'b0110_0011_1001_0101;
        reg_wr(ADDR_MODE, 64'h2);
        reg_wr(ADDR_TX_DEST, 64'd0);
        reg_wr(ADDR_PKT_LEN, 64'd3);
        reg_wr(ADDR_RX_COUNT, 64'd8);
        reg_wr(ADDR_TX_COUNT, 64'd8);
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            stall = stall_pat[i % 16];
            @(negedge clk);
            if (!tx_tvalid && !rx_tready) begin
                done = 1'b1;
                break;
            end
        end
        stall = 1'b0;
        chk("t4_idle", done, 1'b1);
        chk("t4_stalls_seen", stall_cnt != 0, 1'b1);
        chk("t4_stable", unstable, 1'b0);
        chk("t4_beat7", cap_data[7], {16{32'h0000_0007}});
        reg_rd(ADDR_TX_CYC, d);    chk("t4_txcyc", d, 64'(8 + stall_cnt));
        reg_rd(ADDR_ERR_COUNT, d); chk("t4_err", d, 64'd0);

        // Corrupt beat 4 data and drop tlast on beat 7.
        clr_mon();
        corrupt_en = 1'b1;
        reg_wr(ADDR_RX_COUNT, 64'd8);
        reg_wr(ADDR_TX_COUNT, 64'd8);
        wait_idle("t5_idle");
        corrupt_en = 1'b0;
        reg_rd(ADDR_ERR_COUNT, d); chk("t5_err", d, 64'd2);
        reg_rd(ADDR_FIRST_ERR, d); chk("t5_first_err", d, 64'd4);
        reg_rd(ADDR_LAST_CNT, d);  chk("t5_lastcnt", d, 64'd1);

        // Ignored TX_COUNT write, then reset mid-packet.
        clr_mon();
        stall = 1'b1;
        reg_wr(ADDR_MODE, 64'h0);
        reg_wr(ADDR_RX_COUNT, 64'd4);
        reg_wr(ADDR_TX_COUNT, 64'd4);
        reg_wr(ADDR_TX_COUNT, 64'd2);
        reg_rd(ADDR_STATUS, d);   chk("t6_status", d, 64'h7);
        reg_rd(ADDR_TX_COUNT, d); chk("t6_txcount_kept", d, 64'd4);
        stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        stall = 1'b1;
        req.valid = 1'b1; req.is_write = 1'b0; req.addr = ADDR_TX_COUNT;
        @(posedge clk);
        #1;
        chk("t6_pre_resp_valid", resp.valid, 1'b1);
        chk("t6_pre_resp_data", resp.data, 64'd2);
        chk("t6_pre_tvalid", tx_tvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_tvalid", tx_tvalid, 1'b0);
        chk("t6_rst_resp_valid", resp.valid, 1'b0);
        chk("t6_rst_tready", rx_tready, 1'b0);
        req = '0;
        stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        reg_rd(ADDR_STATUS, d);    chk("t6_post_status", d, 64'd0);
        reg_rd(ADDR_TX_COUNT, d);  chk("t6_post_txcount", d, 64'd0);
        reg_rd(ADDR_FIRST_ERR, d); chk("t6_post_first_err", d, 64'h7_FFFF_FFFF);
        reg_rd(ADDR_SEED, d);      chk("t6_post_seed", d, 64'd1);
        reg_rd(ADDR_PKT_LEN, d);   chk("t6_post_pkt_len", d, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
